// File: rtl/ps2_rx_pkg.sv
// Shared constants for the PS/2 scan-code receiver: FSM encoding, prefix bytes
// and the frame parity rule.
package ps2_rx_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return (^data) ^ parity;
  endfunction

endpackage

// File: rtl/ps2_rx_filter.sv
// PS/2 pin conditioning: two-flop synchronisers, a FILTER_LEN-sample glitch
// filter on ps2_clk and a one-cycle pulse on each filtered falling edge.
module ps2_rx_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_s
);

  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       filt_q, filt_d;
  logic [3:0] cnt_q, cnt_d;
  logic       fall_q, fall_d;

  // NOTE: defaults come first so every path assigns every signal and no latch is inferred.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    fall_d = 1'b0;
    if (clk_sync_q[1] != filt_q) begin
      if (cnt_q == 4'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q[1];
        fall_d = filt_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Synchronisers and filter load 1 so an idle bus does not look like an edge after reset.
  // NOTE: non-blocking assignments make every flop sample pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      cnt_q       <= '0;
      fall_q      <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      fall_q      <= fall_d;
    end
  end

  assign fall   = fall_q;
  assign data_s = data_sync_q[1];

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: frames, checks and folds E0/F0 prefixes into one
// strobed key event. Define PS2_RX_TIMEOUT_EN to abort stalled frames after TIMEOUT_CYC.
module ps2_scancode_rx
  import ps2_rx_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 12000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       frame_err,
  output logic       busy
);

  logic       fall;
  logic       data_s;
  logic       timeout_hit;
  logic       frame_ok;

  logic [1:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic       key_valid_q, key_valid_d;
  logic [7:0] key_code_q, key_code_d;
  logic       key_ext_q, key_ext_d;
  logic       key_break_q, key_break_d;
  logic       frame_err_q, frame_err_d;

  ps2_rx_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk     (clk),
    .reset_n (reset_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .fall    (fall),
    .data_s  (data_s)
  );

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    if (fall || state_q == ST_IDLE) to_cnt_d = '0;
    else                            to_cnt_d = to_cnt_q + TO_W'(1);
  end

  assign timeout_hit = (state_q != ST_IDLE) && !fall && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) to_cnt_q <= '0;
    else          to_cnt_q <= to_cnt_d;
  end
`else
  // Without the timeout a truncated frame waits for further edges; TIMEOUT_CYC has no effect.
  assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

  assign frame_ok = odd_parity_ok(shift_q, par_q) && data_s;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_break_d = key_break_q;
    frame_err_d = 1'b0;

    if (fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = data_s;
          state_d = ST_STOP;
        end
        default: begin
          state_d = ST_IDLE;
          if (!frame_ok) begin
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
          end else if (shift_q == PS2_PREFIX_EXT) begin
            ext_d = 1'b1;
          end else if (shift_q == PS2_PREFIX_BRK) begin
            brk_d = 1'b1;
          end else begin
            key_valid_d = 1'b1;
            key_code_d  = shift_q;
            key_ext_d   = ext_q;
            key_break_d = brk_q;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
          end
        end
      endcase
    end

    // Timeout fires only on cycles without a fall, so it never collides with a stop-bit result.
    if (timeout_hit) begin
      state_d     = ST_IDLE;
      ext_d       = 1'b0;
      brk_d       = 1'b0;
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_break_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_break_q <= key_break_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
  assign key_break = key_break_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
